// File: rtl/sockit_spi_xip_seq.sv
// sockit_spi_xip_seq
//    Read-transaction sequencer for the SPI master serializer. A flash read
//    request is turned into an ordered stream of serializer command words
//    (opcode, address, dummy, data chunks, deselect). The opcode and address
//    phases also carry a matching write-data word. Returned read words are
//    counted so that completion can be reported.
//
//    Build option: SOCKIT_SPI_XIP_QUAD_EN
//       defined   : cfg_qio selects quad I/O (opcode 0xEB, iom=3 after opcode)
//       undefined : single I/O only (opcode 0x03), cfg_qio ignored
//
//    Ports
//       clk, rst_n              clock, synchronous active-low reset
//       cfg_sss/cfg_dmy/cfg_qio slave select mask, dummy cycles, quad request
//       req_vld/req_rdy         request handshake, req_adr/req_len payload
//       cmd_vld/cmd_rdy         command handshake
//       cmd_sso..cmd_cnt        command fields
//       sdw_vld/sdw_rdy/sdw_dat write-data stream (MSB aligned)
//       sdr_trn                 one read word accepted downstream
//       busy, done              transaction in flight, completion pulse
//
//    state  | meaning
//    -------+-----------------------------------------------------------
//    IDLE   | ready for a request
//    OPC    | opcode command + opcode write word
//    ADR    | address command + address write word
//    DMY    | dummy cycles (skipped when cfg_dmy=0)
//    DAT    | one read command per data word, repeated while bytes remain
//    END    | deselect gap command
//    WAIT   | wait for all outstanding read words, then pulse done
module sockit_spi_xip_seq #(
   parameter int ADW = 24,
   parameter int SDW = 32,
   parameter int SSW = 8,
   parameter int LNW = 16
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic [SSW-1:0] cfg_sss,
   input  logic [3:0]     cfg_dmy,
   input  logic           cfg_qio,
   input  logic           req_vld,
   output logic           req_rdy,
   input  logic [ADW-1:0] req_adr,
   input  logic [LNW-1:0] req_len,
   output logic           cmd_vld,
   input  logic           cmd_rdy,
   output logic [SSW-1:0] cmd_sso,
   output logic           cmd_cke,
   output logic           cmd_die,
   output logic           cmd_doe,
   output logic [1:0]     cmd_iom,
   output logic [7:0]     cmd_cnt,
   output logic           sdw_vld,
   input  logic           sdw_rdy,
   output logic [SDW-1:0] sdw_dat,
   input  logic           sdr_trn,
   output logic           busy,
   output logic           done
);

   localparam int BPW = SDW/8;

   typedef enum logic [2:0] {
      S_IDLE, S_OPC, S_ADR, S_DMY, S_DAT, S_END, S_WAIT
   } state_t;

   typedef struct packed {
      logic [SSW-1:0] sso;
      logic           cke;
      logic           die;
      logic           doe;
      logic [1:0]     iom;
      logic [7:0]     cnt;
   } cmd_t;

   state_t         state;
   state_t         nxt_st;
   cmd_t           cmd_q;
   cmd_t           nxt_cmd;
   logic [ADW-1:0] adr_q;
   logic [LNW-1:0] rem_q;
   logic [LNW-1:0] rem_nxt;
   logic [LNW-1:0] r_sel;
   logic [LNW-1:0] dat_b;
   logic [LNW-1:0] out_q;
   logic           cmd_sent;
   logic           sdw_sent;
   logic           cmd_x;
   logic           sdw_x;
   logic           pair_done;
   logic           adv;
   logic           inc;
   logic           dec;
   logic           quad;
   logic           quad_sel;
   logic [1:0]     iom_ph;
   logic [SDW-1:0] opc_word;
   logic [SDW-1:0] adr_word;

`ifdef SOCKIT_SPI_XIP_QUAD_EN
   logic quad_q;

   always_ff @(posedge clk) begin
      if (!rst_n)
         quad_q <= 1'b0;
      else if (state == S_IDLE && req_vld)
         quad_q <= cfg_qio;
   end

   assign quad     = quad_q;
   // the opcode word is loaded on the acceptance edge, before quad_q settles
   assign quad_sel = (state == S_IDLE) ? cfg_qio : quad_q;
`else
   logic unused_qio;
   assign unused_qio = cfg_qio;
   assign quad       = 1'b0;
   assign quad_sel   = 1'b0;
`endif

   assign cmd_x     = cmd_vld & cmd_rdy;
   assign sdw_x     = sdw_vld & sdw_rdy;
   assign pair_done = (cmd_sent | cmd_x) & (sdw_sent | sdw_x);
   assign iom_ph    = quad ? 2'd3 : 2'd1;
   assign opc_word  = SDW'(quad_sel ? 8'hEB : 8'h03) << (SDW-8);
   assign adr_word  = SDW'(adr_q) << (SDW-ADW);

   // chunk size of the data command being issued now
   assign dat_b   = (rem_q < LNW'(BPW)) ? rem_q : LNW'(BPW);
   assign rem_nxt = rem_q - dat_b;

   assign inc = (state == S_DAT) & cmd_x;
   assign dec = sdr_trn & (out_q != '0);

   always_comb begin
      adv    = 1'b0;
      nxt_st = state;
      case (state)
         S_IDLE: begin adv = req_vld;   nxt_st = S_OPC; end
         S_OPC:  begin adv = pair_done; nxt_st = S_ADR; end
         S_ADR: begin
            adv = pair_done;
            if (cfg_dmy != 4'd0)    nxt_st = S_DMY;
            else if (rem_q != '0)   nxt_st = S_DAT;
            else                    nxt_st = S_END;
         end
         S_DMY: begin
            adv    = cmd_x;
            nxt_st = (rem_q != '0) ? S_DAT : S_END;
         end
         S_DAT: begin
            adv    = cmd_x;
            nxt_st = (rem_nxt != '0) ? S_DAT : S_END;
         end
         S_END:  begin adv = cmd_x;         nxt_st = S_WAIT; end
         S_WAIT: begin adv = (out_q == '0); nxt_st = S_IDLE; end
         default: begin adv = 1'b1;         nxt_st = S_IDLE; end
      endcase
   end

   // fields of the command that follows; a repeated data command sizes
   // itself from the count left after the current one
   always_comb begin
      nxt_cmd = cmd_q;
      r_sel   = (state == S_DAT) ? rem_nxt : rem_q;
      if (r_sel > LNW'(BPW))
         r_sel = LNW'(BPW);
      case (nxt_st)
         S_OPC: nxt_cmd = '{cfg_sss, 1'b1, 1'b0, 1'b1, 2'd1, 8'd8};
         S_ADR: nxt_cmd = '{cfg_sss, 1'b1, 1'b0, 1'b1, iom_ph,
                            quad ? 8'(ADW/4) : 8'(ADW)};
         S_DMY: nxt_cmd = '{cfg_sss, 1'b1, 1'b0, 1'b0, iom_ph, {4'd0, cfg_dmy}};
         S_DAT: nxt_cmd = '{cfg_sss, 1'b1, 1'b1, 1'b0, iom_ph,
                            quad ? 8'(r_sel << 1) : 8'(r_sel << 3)};
         S_END: nxt_cmd = '{'0, 1'b0, 1'b0, 1'b0, 2'd1, 8'd1};
         default: nxt_cmd = cmd_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state    <= S_IDLE;
         req_rdy  <= 1'b1;
         cmd_vld  <= 1'b0;
         sdw_vld  <= 1'b0;
         busy     <= 1'b0;
         done     <= 1'b0;
         cmd_q    <= '{'0, 1'b0, 1'b0, 1'b0, 2'd1, 8'd0};
         sdw_dat  <= '0;
         adr_q    <= '0;
         rem_q    <= '0;
         out_q    <= '0;
         cmd_sent <= 1'b0;
         sdw_sent <= 1'b0;
      end else begin
         done  <= 1'b0;
         out_q <= out_q + LNW'(inc) - LNW'(dec);
         if (adv) begin
            state    <= nxt_st;
            cmd_q    <= nxt_cmd;
            cmd_sent <= 1'b0;
            sdw_sent <= 1'b0;
            cmd_vld  <= nxt_st inside {S_OPC, S_ADR, S_DMY, S_DAT, S_END};
            sdw_vld  <= nxt_st inside {S_OPC, S_ADR};
            case (state)
               S_IDLE: begin
                  adr_q   <= req_adr;
                  rem_q   <= req_len;
                  req_rdy <= 1'b0;
                  busy    <= 1'b1;
                  sdw_dat <= opc_word;
               end
               S_OPC:  sdw_dat <= adr_word;
               S_DAT:  rem_q   <= rem_nxt;
               S_WAIT: begin
                  done    <= 1'b1;
                  busy    <= 1'b0;
                  req_rdy <= 1'b1;
               end
               default: ;
            endcase
         end else begin
            // only OPC/ADR can see a lone transfer: hold the other stream
            if (cmd_x) begin
               cmd_vld  <= 1'b0;
               cmd_sent <= 1'b1;
            end
            if (sdw_x) begin
               sdw_vld  <= 1'b0;
               sdw_sent <= 1'b1;
            end
         end
      end
   end

   assign cmd_sso = cmd_q.sso;
   assign cmd_cke = cmd_q.cke;
   assign cmd_die = cmd_q.die;
   assign cmd_doe = cmd_q.doe;
   assign cmd_iom = cmd_q.iom;
   assign cmd_cnt = cmd_q.cnt;

endmodule

// File: tb/tb_sockit_spi_xip_seq.sv
module tb_sockit_spi_xip_seq;
   localparam int ADW = 24;
   localparam int SDW = 32;
   localparam int SSW = 8;
   localparam int LNW = 16;

   typedef logic [20:0] cw_t;   // {sso, cke, die, doe, iom, cnt}

   logic           clk = 1'b0;
   logic           rst_n;
   logic [SSW-1:0] cfg_sss;
   logic [3:0]     cfg_dmy;
   logic           cfg_qio;
   logic           req_vld;
   logic           req_rdy;
   logic [ADW-1:0] req_adr;
   logic [LNW-1:0] req_len;
   logic           cmd_vld;
   logic           cmd_rdy;
   logic [SSW-1:0] cmd_sso;
   logic           cmd_cke;
   logic           cmd_die;
   logic           cmd_doe;
   logic [1:0]     cmd_iom;
   logic [7:0]     cmd_cnt;
   logic           sdw_vld;
   logic           sdw_rdy;
   logic [SDW-1:0] sdw_dat;
   logic           sdr_trn;
   logic           busy;
   logic           done;

   cw_t            exp_cmd[$];
   cw_t            obs_cmd[$];
   logic [SDW-1:0] exp_sdw[$];
   logic [SDW-1:0] obs_sdw[$];
   int             done_cnt = 0;
   int             ndat = 0;
   int             total = 0;
   int             bad = 0;
   int             rdy_mode = 0;   // 0: always ready, 1: random, 2: manual

   always #5 clk = ~clk;

   sockit_spi_xip_seq #(.ADW(ADW), .SDW(SDW), .SSW(SSW), .LNW(LNW)) dut (
      .clk(clk), .rst_n(rst_n),
      .cfg_sss(cfg_sss), .cfg_dmy(cfg_dmy), .cfg_qio(cfg_qio),
      .req_vld(req_vld), .req_rdy(req_rdy), .req_adr(req_adr), .req_len(req_len),
      .cmd_vld(cmd_vld), .cmd_rdy(cmd_rdy), .cmd_sso(cmd_sso), .cmd_cke(cmd_cke),
      .cmd_die(cmd_die), .cmd_doe(cmd_doe), .cmd_iom(cmd_iom), .cmd_cnt(cmd_cnt),
      .sdw_vld(sdw_vld), .sdw_rdy(sdw_rdy), .sdw_dat(sdw_dat),
      .sdr_trn(sdr_trn), .busy(busy), .done(done)
   );

   // transfer monitor: records what actually crossed each handshake
   always @(negedge clk) begin
      if (rst_n) begin
         if (cmd_vld && cmd_rdy)
            obs_cmd.push_back({cmd_sso, cmd_cke, cmd_die, cmd_doe, cmd_iom, cmd_cnt});
         if (sdw_vld && sdw_rdy)
            obs_sdw.push_back(sdw_dat);
         if (done)
            done_cnt++;
      end
   end

   function automatic cw_t mk(int sso, int cke, int die, int doe, int iom, int cnt);
      return {8'(sso), 1'(cke), 1'(die), 1'(doe), 2'(iom), 8'(cnt)};
   endfunction

   task automatic check(string tag, logic [63:0] obs, logic [63:0] expv);
      total++;
      assert (obs === expv) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      if (rdy_mode == 1) begin
         cmd_rdy = 1'($urandom_range(0, 1));
         sdw_rdy = 1'($urandom_range(0, 1));
      end
   endtask

   // reference: the command/data stream a flash read must produce
   task automatic build_exp(logic [23:0] adr, int len, int dmy, logic qio, logic [7:0] sss);
      logic q;
      int   rem;
      int   b;
      int   iom;
`ifdef SOCKIT_SPI_XIP_QUAD_EN
      q = qio;
`else
      q = qio & 1'b0;
`endif
      exp_cmd.delete();
      exp_sdw.delete();
      ndat = 0;
      iom  = q ? 3 : 1;
      exp_cmd.push_back(mk(sss, 1, 0, 1, 1, 8));
      exp_sdw.push_back({(q ? 8'hEB : 8'h03), 24'h0});
      exp_cmd.push_back(mk(sss, 1, 0, 1, iom, q ? ADW/4 : ADW));
      exp_sdw.push_back({adr, 8'h0});
      if (dmy != 0)
         exp_cmd.push_back(mk(sss, 1, 0, 0, iom, dmy));
      rem = len;
      while (rem > 0) begin
         b = (rem < SDW/8) ? rem : SDW/8;
         exp_cmd.push_back(mk(sss, 1, 1, 0, iom, q ? 2*b : 8*b));
         rem -= b;
         ndat++;
      end
      exp_cmd.push_back(mk(0, 0, 0, 0, 1, 1));
   endtask

   task automatic start_txn(string nm, logic [23:0] adr, int len, int dmy, logic qio,
                            logic [7:0] sss);
      build_exp(adr, len, dmy, qio, sss);
      obs_cmd.delete();
      obs_sdw.delete();
      done_cnt = 0;
      cfg_sss  = sss;
      cfg_dmy  = 4'(dmy);
      cfg_qio  = qio;
      // a read word while nothing is outstanding must be ignored
      sdr_trn = 1'b1;
      tick();
      sdr_trn = 1'b0;
      req_adr = adr;
      req_len = 16'(len);
      req_vld = 1'b1;
      tick();
      req_vld = 1'b0;
      check($sformatf("%s/accept", nm), 64'({cmd_vld, busy, req_rdy}), 64'(3'b110));
   endtask

   task automatic finish_txn(string nm);
      int cyc;
      cyc = 0;
      while (obs_cmd.size() < exp_cmd.size() && cyc < 500) begin
         tick();
         cyc++;
      end
      check($sformatf("%s/cmd_timeout", nm), 64'(cyc < 500), 64'(1));
      check($sformatf("%s/wait_busy", nm), 64'({busy, 1'(done_cnt)}), 64'(2'b10));
      for (int i = 0; i < ndat; i++) begin
         sdr_trn = 1'b1;
         tick();
         sdr_trn = 1'b0;
         if (i + 1 < ndat && $urandom_range(0, 1) == 1)
            tick();
      end
      cyc = 0;
      while (done_cnt == 0 && cyc < 20) begin
         tick();
         cyc++;
      end
      tick();
      tick();
      check($sformatf("%s/done_pulses", nm), 64'(done_cnt), 64'(1));
      check($sformatf("%s/idle", nm), 64'({busy, req_rdy, done}), 64'(3'b010));
      check($sformatf("%s/ncmd", nm), 64'(obs_cmd.size()), 64'(exp_cmd.size()));
      for (int i = 0; i < exp_cmd.size(); i++)
         check($sformatf("%s/cmd%0d", nm, i),
               64'((i < obs_cmd.size()) ? obs_cmd[i] : 21'hx), 64'(exp_cmd[i]));
      check($sformatf("%s/nsdw", nm), 64'(obs_sdw.size()), 64'(exp_sdw.size()));
      for (int i = 0; i < exp_sdw.size(); i++)
         check($sformatf("%s/sdw%0d", nm, i),
               64'((i < obs_sdw.size()) ? obs_sdw[i] : 32'hx), 64'(exp_sdw[i]));
   endtask

   initial begin
      int cyc;
      int snap;
      rst_n   = 1'b0;
      cfg_sss = 8'hA5;
      cfg_dmy = 4'd3;
      cfg_qio = 1'b0;
      req_vld = 1'b0;
      req_adr = '0;
      req_len = '0;
      cmd_rdy = 1'b1;
      sdw_rdy = 1'b1;
      sdr_trn = 1'b0;

      repeat (3) tick();
      check("rst/handshake", 64'({req_rdy, cmd_vld, sdw_vld, busy, done}), 64'(5'b10000));
      check("rst/fields", 64'({cmd_sso, cmd_cke, cmd_die, cmd_doe, cmd_iom, cmd_cnt}),
            64'(mk(0, 0, 0, 0, 1, 0)));
      rst_n = 1'b1;
      tick();
      check("rst/release", 64'({req_rdy, cmd_vld, busy}), 64'(3'b100));

      rdy_mode = 0;
      start_txn("single", 24'h123456, 4, 0, 1'b0, 8'h01);
      finish_txn("single");
      start_txn("chunk", 24'h000100, 9, 0, 1'b0, 8'h02);
      finish_txn("chunk");
      start_txn("quad", 24'h00ABCD, 4, 6, 1'b1, 8'h04);
      finish_txn("quad");
      start_txn("zero", 24'hFFFFFF, 0, 0, 1'b0, 8'h80);
      finish_txn("zero");

      // write-data backpressure during the opcode phase
      rdy_mode = 2;
      cmd_rdy  = 1'b1;
      sdw_rdy  = 1'b0;
      start_txn("bp", 24'hABCDEF, 4, 0, 1'b0, 8'h10);
      for (int k = 0; k < 5; k++) begin
         tick();
         check($sformatf("bp/hold%0d", k), 64'({sdw_vld, sdw_dat}), 64'({1'b1, 32'h03000000}));
      end
      check("bp/one_cmd", 64'(obs_cmd.size()), 64'(1));
      check("bp/no_sdw", 64'({cmd_vld, 8'(obs_sdw.size())}), 64'(0));
      sdw_rdy  = 1'b1;
      rdy_mode = 0;
      finish_txn("bp");

      rdy_mode = 1;
      for (int t = 0; t < 10; t++)
         begin
            string nm;
            nm = $sformatf("rnd%0d", t);
            start_txn(nm, 24'($urandom), $urandom_range(0, 20), $urandom_range(0, 15),
                      1'($urandom_range(0, 1)), 8'($urandom));
            finish_txn(nm);
         end

      // reset in the middle of the data phase
      rdy_mode = 0;
      cmd_rdy  = 1'b1;
      sdw_rdy  = 1'b1;
      start_txn("abort", 24'h020000, 40, 0, 1'b0, 8'h03);
      cyc = 0;
      while (obs_cmd.size() < 3 && cyc < 50) begin
         tick();
         cyc++;
      end
      check("abort/reach_dat", 64'(cyc < 50), 64'(1));
      snap  = done_cnt;
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      check("abort/state", 64'({cmd_vld, sdw_vld, busy, req_rdy, done}), 64'(5'b00010));
      repeat (5) tick();
      check("abort/quiet", 64'({cmd_vld, 8'(done_cnt - snap)}), 64'(0));

      rdy_mode = 1;
      start_txn("post", 24'h3456AB, 7, 2, 1'b1, 8'h0F);
      finish_txn("post");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
